// File: rtl/yadan_pipe_pkg.sv
// Shared pipeline definitions: occupancy width, stage-state encoding and the ID/EX payload layout.
package yadan_pipe_pkg;

  localparam int PIPE_OCC_W = 2;

  // Encoded as {skid_v, main_v}; 2'b10 cannot occur in a healthy stage.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_BAD   = 2'b10,
    OCC_FULL  = 2'b11
  } occ_state_e;

  typedef enum logic [7:0] {
    ALUOP_NONE = 8'h00,
    ALUOP_ADD  = 8'h01,
    ALUOP_SUB  = 8'h02,
    ALUOP_AND  = 8'h03,
    ALUOP_OR   = 8'h04,
    ALUOP_XOR  = 8'h05,
    ALUOP_SLL  = 8'h06,
    ALUOP_SRL  = 8'h07
  } aluop_e;

  typedef enum logic [2:0] {
    RES_NONE  = 3'd0,
    RES_LOGIC = 3'd1,
    RES_SHIFT = 3'd2,
    RES_ARITH = 3'd3,
    RES_JUMP  = 3'd4,
    RES_LOAD  = 3'd5
  } alusel_e;

  localparam int ID_EX_W          = 64;
  localparam int ID_EX_ALUOP_LSB  = 0;
  localparam int ID_EX_ALUOP_W    = 8;
  localparam int ID_EX_ALUSEL_LSB = 8;
  localparam int ID_EX_ALUSEL_W   = 3;
  localparam int ID_EX_WREG_BIT   = 11;
  localparam int ID_EX_WCSR_BIT   = 12;
  localparam int ID_EX_WADDR_LSB  = 13;
  localparam int ID_EX_WADDR_W    = 5;
  localparam int ID_EX_OPER_LSB   = 18;
  localparam int ID_EX_OPER_W     = 46;

  localparam logic [4:0] NOP_REG_ADDR = 5'd0;

  localparam logic [ID_EX_W-1:0] ID_EX_BUBBLE = {
    {ID_EX_OPER_W{1'b0}}, NOP_REG_ADDR, 1'b0, 1'b0, 3'(RES_NONE), 8'(ALUOP_NONE)
  };

  function automatic logic [ID_EX_W-1:0] id_ex_pack(
    input aluop_e                  op,
    input alusel_e                 sel,
    input logic                    wreg,
    input logic                    wcsr,
    input logic [4:0]              waddr,
    input logic [ID_EX_OPER_W-1:0] oper
  );
    return {oper, waddr, wcsr, wreg, 3'(sel), 8'(op)};
  endfunction

endpackage

// File: rtl/pipe_stage_skid_entry.sv
// One storage slot of a pipeline stage: a valid bit plus a payload register with load and clear.
module pipe_entry
  import yadan_pipe_pkg::*;
#(
  parameter int                DATA_W   = 64,
  parameter logic [DATA_W-1:0] BUBBLE   = '0,
  parameter bit                CLR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Clear beats load so a kill can never be overridden by a late write.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      if (CLR_DATA) begin
        data_d = BUBBLE;
      end
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= BUBBLE;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline stage register with optional two-entry skid buffer and flush.
module pipe_stage_skid
  import yadan_pipe_pkg::*;
#(
  parameter int                DATA_W   = 64,
  parameter bit                SKID_EN  = 1'b1,
  parameter logic [DATA_W-1:0] BUBBLE   = '0,
  parameter bit                CLR_DATA = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  up_valid_i,
  output logic                  up_ready_o,
  input  logic [DATA_W-1:0]     up_data_i,
  output logic                  dn_valid_o,
  input  logic                  dn_ready_i,
  output logic [DATA_W-1:0]     dn_data_o,
  output logic [PIPE_OCC_W-1:0] occ_o
);

  logic              main_v, skid_v;
  logic [DATA_W-1:0] main_data, skid_data, main_src;
  logic              main_load, main_clear, skid_load, skid_clear;
  logic              push, pop;
  occ_state_e        state;

  // With the skid enabled, ready depends only on held state so the consumer's ready never reaches the producer.
  assign up_ready_o = SKID_EN ? !skid_v : (!main_v | dn_ready_i);
  assign push       = up_valid_i & up_ready_o;
  assign pop        = main_v & dn_ready_i;
  assign state      = occ_state_e'({skid_v, main_v});

  always_comb begin
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    main_src   = up_data_i;
    if (flush_i) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        OCC_EMPTY: main_load = push;
        OCC_ONE: begin
          if (push && pop) begin
            main_load = 1'b1;
          end else if (push) begin
            skid_load = SKID_EN;
          end else if (pop) begin
            main_clear = 1'b1;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            main_load  = 1'b1;
            main_src   = skid_data;
            skid_clear = 1'b1;
          end
        end
        default: begin
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  pipe_entry #(
    .DATA_W  (DATA_W),
    .BUBBLE  (BUBBLE),
    .CLR_DATA(CLR_DATA)
  ) u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (main_load),
    .clear_i(main_clear),
    .data_i (main_src),
    .valid_o(main_v),
    .data_o (main_data)
  );

  pipe_entry #(
    .DATA_W  (DATA_W),
    .BUBBLE  (BUBBLE),
    .CLR_DATA(CLR_DATA)
  ) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (skid_load),
    .clear_i(skid_clear),
    .data_i (up_data_i),
    .valid_o(skid_v),
    .data_o (skid_data)
  );

  assign dn_valid_o = main_v;
  assign dn_data_o  = main_v ? main_data : BUBBLE;
  assign occ_o      = {1'b0, main_v} + {1'b0, skid_v};

  a_skid_implies_main: assert property (@(posedge clk) disable iff (!rst_n)
    skid_v |-> main_v);
  a_no_load_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    skid_load |-> !skid_v);
  a_head_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (dn_valid_o && !dn_ready_i && !flush_i) |=> $stable(dn_data_o));

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a skid build (64-bit) and a single-entry build (160-bit).
module tb_pipe_stage_skid;

  localparam logic [63:0]  BUB_A = 64'hBBBB_0000_0000_0001;
  localparam logic [159:0] BUB_B = '0;

  logic         clk = 1'b0;
  logic         rst_n;

  logic         flushA, upValidA, upReadyA, dnValidA, dnReadyA;
  logic [63:0]  upDataA, dnDataA;
  logic [1:0]   occA;

  logic         flushB, upValidB, upReadyB, dnValidB, dnReadyB;
  logic [159:0] upDataB, dnDataB;
  logic [1:0]   occB;

  int testCount = 0;
  int failCount = 0;

  logic [63:0]  qA[$];
  logic [159:0] qB[$];

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W  (64),
    .SKID_EN (1'b1),
    .BUBBLE  (BUB_A),
    .CLR_DATA(1'b1)
  ) dutA (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flushA),
    .up_valid_i(upValidA),
    .up_ready_o(upReadyA),
    .up_data_i (upDataA),
    .dn_valid_o(dnValidA),
    .dn_ready_i(dnReadyA),
    .dn_data_o (dnDataA),
    .occ_o     (occA)
  );

  pipe_stage_skid #(
    .DATA_W  (160),
    .SKID_EN (1'b0),
    .BUBBLE  (BUB_B),
    .CLR_DATA(1'b0)
  ) dutB (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flushB),
    .up_valid_i(upValidB),
    .up_ready_o(upReadyB),
    .up_data_i (upDataB),
    .dn_valid_o(dnValidB),
    .dn_ready_i(dnReadyB),
    .dn_data_o (dnDataB),
    .occ_o     (occB)
  );

  // Counts one comparison and reports it if the observed value differs from the expected one.
  task automatic checkOutput(input string tag, input logic [159:0] actual, input logic [159:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drives one cycle on the skid build, checks outputs against the queue model, then advances the model.
  task automatic applyStimulus(input logic v, input logic [63:0] d, input logic r, input logic f,
                               output logic pushed);
    logic expReady;
    logic [63:0] unused;
    @(negedge clk);
    upValidA = v; upDataA = d; dnReadyA = r; flushA = f;
    #1;
    expReady = (qA.size() < 2);
    checkOutput("A.up_ready", {159'd0, upReadyA}, {159'd0, expReady});
    checkOutput("A.dn_valid", {159'd0, dnValidA}, {159'd0, qA.size() != 0});
    checkOutput("A.occ", {158'd0, occA}, 160'(qA.size()));
    if (qA.size() != 0) checkOutput("A.dn_data", {96'd0, dnDataA}, {96'd0, qA[0]});
    else                checkOutput("A.bubble", {96'd0, dnDataA}, {96'd0, BUB_A});
    pushed = v & expReady;
    if (r && qA.size() != 0) unused = qA.pop_front();
    if (f) qA.delete();
    else if (pushed) qA.push_back(d);
  endtask

  // Same as applyStimulus but for the single-entry 160-bit build.
  task automatic stepB(input logic v, input logic [159:0] d, input logic r, input logic f);
    logic expReady;
    logic [159:0] unused;
    @(negedge clk);
    upValidB = v; upDataB = d; dnReadyB = r; flushB = f;
    #1;
    expReady = (qB.size() == 0) || r;
    checkOutput("B.up_ready", {159'd0, upReadyB}, {159'd0, expReady});
    checkOutput("B.dn_valid", {159'd0, dnValidB}, {159'd0, qB.size() != 0});
    checkOutput("B.occ", {158'd0, occB}, 160'(qB.size()));
    if (qB.size() != 0) checkOutput("B.dn_data", dnDataB, qB[0]);
    else                checkOutput("B.bubble", dnDataB, BUB_B);
    if (r && qB.size() != 0) unused = qB.pop_front();
    if (f) qB.delete();
    else if (v && expReady) qB.push_back(d);
  endtask

  // Holds a word on the producer side until it is accepted, with a cycle bound.
  task automatic pushWord(input logic [63:0] d, input logic r);
    logic pushed;
    pushed = 1'b0;
    for (int c = 0; c < 10 && !pushed; c++) applyStimulus(1'b1, d, r, 1'b0, pushed);
    checkOutput("A.push_accepted", {159'd0, pushed}, 160'd1);
  endtask

  initial begin
    logic        pushed;
    logic [63:0] bp[3];
    logic [63:0] cur;
    int          idx;

    rst_n = 1'b0;
    flushA = 0; upValidA = 0; upDataA = '0; dnReadyA = 0;
    flushB = 0; upValidB = 0; upDataB = '0; dnReadyB = 0;
    #3;
    checkOutput("rst.A.dn_valid", {159'd0, dnValidA}, 160'd0);
    checkOutput("rst.A.occ", {158'd0, occA}, 160'd0);
    checkOutput("rst.A.dn_data", {96'd0, dnDataA}, {96'd0, BUB_A});
    checkOutput("rst.A.up_ready", {159'd0, upReadyA}, 160'd1);
    checkOutput("rst.B.up_ready", {159'd0, upReadyB}, 160'd1);
    checkOutput("rst.B.occ", {158'd0, occB}, 160'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Streaming: back-to-back pushes with the consumer always ready.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 64'h11 + 64'(i), 1'b1, 1'b0, pushed);
    repeat (2) applyStimulus(1'b0, '0, 1'b1, 1'b0, pushed);

    // Backpressure: A1..A3 offered while the consumer stalls, then released.
    bp[0] = 64'hA1; bp[1] = 64'hA2; bp[2] = 64'hA3;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      cur = (idx < 3) ? bp[idx] : 64'h0;
      applyStimulus(idx < 3, cur, 1'b0, 1'b0, pushed);
      if (pushed) idx++;
    end
    checkOutput("bp.held_by_producer", 160'(idx), 160'd2);
    for (int c = 0; c < 20 && (idx < 3 || qA.size() != 0); c++) begin
      cur = (idx < 3) ? bp[idx] : 64'h0;
      applyStimulus(idx < 3, cur, 1'b1, 1'b0, pushed);
      if (pushed) idx++;
    end
    checkOutput("bp.drained", {159'd0, (idx == 3) && (qA.size() == 0)}, 160'd1);

    // Flush while FULL with a simultaneous push of B3, then a fresh push of C0.
    pushWord(64'hB1, 1'b0);
    pushWord(64'hB2, 1'b0);
    applyStimulus(1'b1, 64'hB3, 1'b0, 1'b1, pushed);
    applyStimulus(1'b1, 64'hC0, 1'b0, 1'b0, pushed);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, pushed);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, pushed);

    // Flush with a same-cycle pop: D1 leaves, D2 is killed.
    pushWord(64'hD1, 1'b0);
    pushWord(64'hD2, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, pushed);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, pushed);

    // Asynchronous reset in the middle of a cycle with two entries held.
    pushWord(64'hE1, 1'b0);
    pushWord(64'hE2, 1'b0);
    @(negedge clk);
    upValidA = 1'b0; dnReadyA = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst.dn_valid", {159'd0, dnValidA}, 160'd0);
    checkOutput("arst.occ", {158'd0, occA}, 160'd0);
    checkOutput("arst.dn_data", {96'd0, dnDataA}, {96'd0, BUB_A});
    checkOutput("arst.up_ready", {159'd0, upReadyA}, 160'd1);
    qA.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic on the skid build.
    for (int c = 0; c < 1500; c++)
      applyStimulus(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 15) == 0), pushed);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, pushed);

    // Single-entry build: full throughput, then random traffic.
    for (int c = 0; c < 40; c++)
      stepB(1'b1, {$urandom, $urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
    for (int c = 0; c < 2000; c++)
      stepB(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom, $urandom},
            1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    stepB(1'b0, '0, 1'b0, 1'b1);
    stepB(1'b0, '0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
